// File: rtl/logic_unit_stream.sv
// Registered bitwise logic unit on a valid/ready stream, with AND/OR burst
// accumulation. One output register; a result holds until the consumer takes it.
module logic_unit_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_count,
  output logic             out_trunc
);

  typedef enum logic {StIdle, StAccum} state_e;

  state_e             r_state, w_state_d;
  logic [WIDTH-1:0]   r_acc, w_acc_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d;
  logic               r_op_or, w_op_or_d;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_y;
  logic               r_out_zero;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_out_trunc;

  logic               w_accept;
  logic               w_emit;
  logic [WIDTH-1:0]   w_emit_y;
  logic [CNT_W-1:0]   w_emit_cnt;
  logic               w_emit_trunc;
  logic [WIDTH-1:0]   w_fold;
  logic [CNT_W-1:0]   w_n;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_fold    = r_op_or ? (r_acc | in_a) : (r_acc & in_a);
  assign w_n       = r_cnt + CNT_W'(1);

  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign out_zero  = r_out_zero;
  assign out_count = r_out_count;
  assign out_trunc = r_out_trunc;

  always_comb begin
    w_state_d    = r_state;
    w_acc_d      = r_acc;
    w_cnt_d      = r_cnt;
    w_op_or_d    = r_op_or;
    w_emit       = 1'b0;
    w_emit_y     = '0;
    w_emit_cnt   = CNT_W'(1);
    w_emit_trunc = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        StIdle: begin
          case (in_op)
            3'd0: begin w_emit = 1'b1; w_emit_y = in_a & in_b;    end
            3'd1: begin w_emit = 1'b1; w_emit_y = in_a | in_b;    end
            3'd2: begin w_emit = 1'b1; w_emit_y = ~in_a;          end
            3'd3: begin w_emit = 1'b1; w_emit_y = in_a ^ in_b;    end
            3'd4: begin w_emit = 1'b1; w_emit_y = ~(in_a & in_b); end
            3'd5: begin w_emit = 1'b1; w_emit_y = ~(in_a | in_b); end
            default: begin
              if (in_last) begin
                w_emit   = 1'b1;
                w_emit_y = in_a;
              end else begin
                w_acc_d   = in_a;
                w_cnt_d   = CNT_W'(1);
                w_op_or_d = in_op[0];
                w_state_d = StAccum;
              end
            end
          endcase
        end
        StAccum: begin
          // Latched op governs the whole burst; in_op is ignored here.
          if (in_last || (w_n == CNT_W'(MAX_BURST))) begin
            w_emit       = 1'b1;
            w_emit_y     = w_fold;
            w_emit_cnt   = w_n;
            w_emit_trunc = !in_last;
            w_acc_d      = '0;
            w_cnt_d      = '0;
            w_state_d    = StIdle;
          end else begin
            w_acc_d = w_fold;
            w_cnt_d = w_n;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_op_or     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_zero  <= 1'b0;
      r_out_count <= '0;
      r_out_trunc <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_acc   <= w_acc_d;
      r_cnt   <= w_cnt_d;
      r_op_or <= w_op_or_d;
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_y     <= w_emit_y;
        r_out_zero  <= (w_emit_y == '0);
        r_out_count <= w_emit_cnt;
        r_out_trunc <= w_emit_trunc;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_stream.sv
// Directed bench for logic_unit_stream (WIDTH=8, MAX_BURST=4) with a queue
// scoreboard checked whenever the consumer takes a result.
module tb_logic_unit_stream;

  localparam int unsigned W  = 8;
  localparam int unsigned MB = 4;
  localparam int unsigned CW = $clog2(MB + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [2:0]    in_op;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_y;
  logic          out_zero;
  logic [CW-1:0] out_count;
  logic          out_trunc;

  typedef struct packed {
    logic [W-1:0]  y;
    logic          z;
    logic [CW-1:0] c;
    logic          t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic_unit_stream #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zero  (out_zero),
    .out_count (out_count),
    .out_trunc (out_trunc)
  );

  always #5 clk = ~clk;

  // A transfer happens at the next posedge whenever valid && ready here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $error("FAIL sb_unexpected got y=%h c=%0d t=%b", out_y, out_count, out_trunc);
      end else begin
        exp_t e;
        e = q.pop_front();
        assert ({out_y, out_zero, out_count, out_trunc} === e) else begin
          errors++;
          $error("FAIL sb got y=%h z=%b c=%0d t=%b exp y=%h z=%b c=%0d t=%b",
                 out_y, out_zero, out_count, out_trunc, e.y, e.z, e.c, e.t);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] y, input int c, input logic t);
    exp_t e;
    e.y = y;
    e.z = (y == '0);
    e.c = CW'(c);
    e.t = t;
    q.push_back(e);
  endtask

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] op, input logic last);
    int t;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_last  = last;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 50) begin
        checks++;
        errors++;
        $error("FAIL send_timeout got in_ready=0 exp 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  logic [W-1:0] exp1 [6];
  logic [W-1:0] exp0 [3];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(out_y), 32'd0);
    check("rst_zero", 32'(out_zero), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_trunc", 32'(out_trunc), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic ops, one-cycle latency
    exp0 = '{8'h00, 8'h00, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      push(exp0[i], 1, 1'b0);
      send(8'h00, 8'h00, 3'(i), 1'b0);
      check("lat0_valid", 32'(out_valid), 32'd1);
      check("lat0_y", 32'(out_y), 32'(exp0[i]));
    end
    exp1 = '{8'h30, 8'hFC, 8'h0F, 8'hCC, 8'hCF, 8'h03};
    for (int i = 0; i < 6; i++) begin
      push(exp1[i], 1, 1'b0);
      send(8'hF0, 8'h3C, 3'(i), 1'b0);
      check("lat1_y", 32'(out_y), 32'(exp1[i]));
    end
    @(posedge clk);
    #1;

    // 2: backpressure and back-to-back reload
    out_ready = 1'b0;
    push(8'h0F, 1, 1'b0);
    send(8'hFF, 8'h0F, 3'd0, 1'b0);
    push(8'hFF, 1, 1'b0);
    in_valid = 1'b1;
    in_a     = 8'h0F;
    in_b     = 8'hF0;
    in_op    = 3'd1;
    repeat (2) @(posedge clk);
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_hold_y", 32'(out_y), 32'h0F);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_y", 32'(out_y), 32'hFF);
    @(posedge clk);
    #1;
    check("drain_valid", 32'(out_valid), 32'd0);

    // 3: ACC_OR burst with a bubble
    send(8'h01, 8'h00, 3'd7, 1'b0);
    @(posedge clk);
    #1;
    send(8'h02, 8'h00, 3'd1, 1'b0);
    check("acc_no_early", 32'(out_valid), 32'd0);
    push(8'h07, 3, 1'b0);
    send(8'h04, 8'h00, 3'd0, 1'b1);
    @(posedge clk);
    #1;

    // 4: ACC_AND truncated at MAX_BURST, then fresh burst
    send(8'hFF, 8'h00, 3'd6, 1'b0);
    send(8'hFE, 8'h00, 3'd6, 1'b0);
    send(8'hFC, 8'h00, 3'd6, 1'b0);
    push(8'hF8, 4, 1'b1);
    send(8'hF8, 8'h00, 3'd6, 1'b0);
    check("trunc_flag", 32'(out_trunc), 32'd1);
    send(8'hF0, 8'h00, 3'd6, 1'b0);
    push(8'hE0, 2, 1'b0);
    send(8'hE0, 8'h00, 3'd6, 1'b1);
    @(posedge clk);
    #1;

    // 5: single-beat accumulate of zero
    push(8'h00, 1, 1'b0);
    send(8'h00, 8'hFF, 3'd6, 1'b1);
    check("single_zero", 32'(out_zero), 32'd1);
    @(posedge clk);
    #1;

    // 6: reset mid-burst drops the partial result
    send(8'h55, 8'h00, 3'd7, 1'b0);
    send(8'hAA, 8'h00, 3'd7, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_outs", 32'({out_y, out_zero, out_count, out_trunc}), 32'd0);
    send(8'h10, 8'h00, 3'd7, 1'b0);
    check("mrst_no_out", 32'(out_valid), 32'd0);
    push(8'h30, 2, 1'b0);
    send(8'h20, 8'h00, 3'd7, 1'b1);
    check("mrst_y", 32'(out_y), 32'h30);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
